id_decode_stage: RTL and testbench

//  Instruction-decode stage and ID/EX pipeline register; the producer side of the ALU interface.

---
 rtl/id_decode_stage.sv | 211 +++++++++++++++++++++
 tb/tb_id_decode_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_stage.sv
// Instruction-decode stage with ID/EX pipeline register, RAW-hazard stall and valid/ready on both sides.
// Optional ILLEGAL_OP_TRAP_EN adds an illegal_op pulse for accepted unmapped opcodes.
module id_decode_stage #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instr,
  output logic [REG_ADDR_W-1:0]  rf_addr1,
  output logic [REG_ADDR_W-1:0]  rf_addr2,
  input  logic [31:0]            rf_val1,
  input  logic [31:0]            rf_val2,
  input  logic [REG_ADDR_W-1:0]  exe_dest,
  input  logic                   exe_wb_en,
  input  logic [REG_ADDR_W-1:0]  mem_dest,
  input  logic                   mem_wb_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             exe_cmd,
  output logic [31:0]            val1,
  output logic [31:0]            val2,
  output logic [31:0]            st_val,
  output logic [REG_ADDR_W-1:0]  dest,
  output logic                   wb_en,
  output logic                   mem_r,
  output logic                   mem_w,
  output logic [1:0]             br_type,
  output logic [STALL_CNT_W-1:0] stall_cnt
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic                   illegal_op
`endif
);

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] imm);
    return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] c);
    return (&c) ? c : c + STALL_CNT_W'(1);
  endfunction

  function automatic logic raw(input logic [REG_ADDR_W-1:0] src,
                               input logic [REG_ADDR_W-1:0] d_exe, input logic en_exe,
                               input logic [REG_ADDR_W-1:0] d_mem, input logic en_mem,
                               input logic [REG_ADDR_W-1:0] d_id,  input logic en_id);
    return (src != '0) && ((en_exe && src == d_exe) || (en_mem && src == d_mem) ||
                           (en_id && src == d_id));
  endfunction

  logic [5:0]              op_p0;
  logic [REG_ADDR_W-1:0]   dst_p0, src1_p0, src2_p0;
  logic [3:0]              cmd_p0;
  logic                    wb_p0, mr_p0, mw_p0, use1_p0, use2_p0, imm_p0, st_p0;
  logic [1:0]              br_p0;
  logic signed [DATA_W-1:0] val2_p0;
  logic                    hazard_p0, accept_p0;

  logic                    vld_p1, wb_p1, mr_p1, mw_p1;
  logic [3:0]              cmd_p1;
  logic [1:0]              br_p1;
  logic signed [DATA_W-1:0] val1_p1, val2_p1, st_p1;
  logic [REG_ADDR_W-1:0]   dest_p1;
  logic [STALL_CNT_W-1:0]  stall_p1;

  // Stage p0: combinational decode, register read addressing and hazard detection
  assign op_p0   = instr[31:26];
  assign dst_p0  = instr[21 +: REG_ADDR_W];
  assign src1_p0 = instr[16 +: REG_ADDR_W];
  assign src2_p0 = st_p0 ? instr[21 +: REG_ADDR_W] : instr[11 +: REG_ADDR_W];

  always_comb begin
    cmd_p0  = 4'b0000;
    wb_p0   = 1'b0;
    mr_p0   = 1'b0;
    mw_p0   = 1'b0;
    br_p0   = 2'b00;
    use1_p0 = 1'b0;
    use2_p0 = 1'b0;
    imm_p0  = 1'b1;
    st_p0   = 1'b0;
    case (op_p0)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_SLL, OP_SRA, OP_SRL: begin
        wb_p0   = 1'b1;
        use1_p0 = 1'b1;
        use2_p0 = 1'b1;
        imm_p0  = 1'b0;
        case (op_p0)
          OP_SUB:  cmd_p0 = 4'b0010;
          OP_AND:  cmd_p0 = 4'b0100;
          OP_OR:   cmd_p0 = 4'b0101;
          OP_NOR:  cmd_p0 = 4'b0110;
          OP_XOR:  cmd_p0 = 4'b0111;
          OP_SLL:  cmd_p0 = 4'b1000;
          OP_SRL:  cmd_p0 = 4'b1001;
          OP_SRA:  cmd_p0 = 4'b1010;
          default: cmd_p0 = 4'b0000;
        endcase
      end
      OP_ADDI: begin wb_p0 = 1'b1; use1_p0 = 1'b1; end
      OP_SUBI: begin wb_p0 = 1'b1; use1_p0 = 1'b1; cmd_p0 = 4'b0010; end
      OP_LD:   begin wb_p0 = 1'b1; mr_p0 = 1'b1; use1_p0 = 1'b1; end
      OP_ST:   begin mw_p0 = 1'b1; use1_p0 = 1'b1; use2_p0 = 1'b1; st_p0 = 1'b1; end
      OP_BEZ:  begin br_p0 = 2'b01; use1_p0 = 1'b1; end
      OP_BNE:  begin br_p0 = 2'b10; use1_p0 = 1'b1; use2_p0 = 1'b1; end
      OP_JMP:  br_p0 = 2'b11;
      default: ;
    endcase
  end

  assign rf_addr1  = src1_p0;
  assign rf_addr2  = src2_p0;
  assign val2_p0   = imm_p0 ? sext16(instr[15:0]) : rf_val2;
  assign hazard_p0 =
    (use1_p0 && raw(src1_p0, exe_dest, exe_wb_en, mem_dest, mem_wb_en, dest_p1, wb_p1 & vld_p1)) ||
    (use2_p0 && raw(src2_p0, exe_dest, exe_wb_en, mem_dest, mem_wb_en, dest_p1, wb_p1 & vld_p1));
  assign in_ready  = ~hazard_p0 & ~flush & (~vld_p1 | out_ready);
  assign accept_p0 = in_valid & in_ready;

  // Stage p1: ID/EX register; flush kills only the control bits, data may stay stale
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      cmd_p1   <= '0;
      val1_p1  <= '0;
      val2_p1  <= '0;
      st_p1    <= '0;
      dest_p1  <= '0;
      wb_p1    <= 1'b0;
      mr_p1    <= 1'b0;
      mw_p1    <= 1'b0;
      br_p1    <= 2'b00;
      stall_p1 <= '0;
    end else begin
      if (flush) begin
        vld_p1 <= 1'b0;
        wb_p1  <= 1'b0;
        mr_p1  <= 1'b0;
        mw_p1  <= 1'b0;
        br_p1  <= 2'b00;
      end else if (accept_p0) begin
        vld_p1  <= 1'b1;
        cmd_p1  <= cmd_p0;
        val1_p1 <= rf_val1;
        val2_p1 <= val2_p0;
        st_p1   <= rf_val2;
        dest_p1 <= dst_p0;
        wb_p1   <= wb_p0;
        mr_p1   <= mr_p0;
        mw_p1   <= mw_p0;
        br_p1   <= br_p0;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
      if (in_valid && hazard_p0)
        stall_p1 <= sat_inc(stall_p1);
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic legal_p0, ill_p1;

  assign legal_p0 = op_p0 inside {OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
                                  OP_SLL, OP_SRA, OP_SRL, OP_ADDI, OP_SUBI, OP_LD, OP_ST,
                                  OP_BEZ, OP_BNE, OP_JMP};

  always_ff @(posedge clk) begin
    if (rst) ill_p1 <= 1'b0;
    else     ill_p1 <= accept_p0 & ~legal_p0;
  end

  assign illegal_op = ill_p1;
`endif

  assign out_valid = vld_p1;
  assign exe_cmd   = cmd_p1;
  assign val1      = val1_p1;
  assign val2      = val2_p1;
  assign st_val    = st_p1;
  assign dest      = dest_p1;
  assign wb_en     = wb_p1;
  assign mem_r     = mr_p1;
  assign mem_w     = mw_p1;
  assign br_type   = br_p1;
  assign stall_cnt = stall_p1;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: a reference decode/hazard model predicts each issued
// instruction and every handshake and counter value cycle by cycle.
module tb_id_decode_stage;

  localparam int SCW  = 4;
  localparam int SMAX = (1 << SCW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, rf_val1, rf_val2, val1, val2, st_val;
  logic [4:0]  rf_addr1, rf_addr2, exe_dest, mem_dest, dest;
  logic        exe_wb_en, mem_wb_en, wb_en, mem_r, mem_w;
  logic [3:0]  exe_cmd;
  logic [1:0]  br_type;
  logic [SCW-1:0] stall_cnt;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        illegal_op;
`endif

  logic [31:0] rf [32];
  assign rf_val1 = rf[rf_addr1];
  assign rf_val2 = rf[rf_addr2];

  id_decode_stage #(.REG_ADDR_W(5), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_val1(rf_val1),
    .rf_val2(rf_val2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .out_valid(out_valid), .out_ready(out_ready), .exe_cmd(exe_cmd),
    .val1(val1), .val2(val2), .st_val(st_val), .dest(dest), .wb_en(wb_en), .mem_r(mem_r),
    .mem_w(mem_w), .br_type(br_type), .stall_cnt(stall_cnt)
`ifdef ILLEGAL_OP_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] v1, v2, sv;
    logic [4:0]  dest;
    logic        wb, mr, mw;
    logic [1:0]  br;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic       m_valid, m_wb, m_ill;
  logic [4:0] m_dest;
  int         m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] ins, output exp_t e, output bit u1,
                                output bit u2, output logic [4:0] a2, output bit legal);
    logic [5:0]  op;
    logic [31:0] imm;
    bit          rtype;
    op    = ins[31:26];
    imm   = {{16{ins[15]}}, ins[15:0]};
    e     = '0;
    u1    = 0;
    u2    = 0;
    legal = 1;
    rtype = 0;
    a2    = ins[15:11];
    case (op)
      6'd1:  begin rtype = 1; e.cmd = 4'd0;  end
      6'd3:  begin rtype = 1; e.cmd = 4'd2;  end
      6'd5:  begin rtype = 1; e.cmd = 4'd4;  end
      6'd6:  begin rtype = 1; e.cmd = 4'd5;  end
      6'd7:  begin rtype = 1; e.cmd = 4'd6;  end
      6'd8:  begin rtype = 1; e.cmd = 4'd7;  end
      6'd10: begin rtype = 1; e.cmd = 4'd8;  end
      6'd12: begin rtype = 1; e.cmd = 4'd9;  end
      6'd11: begin rtype = 1; e.cmd = 4'd10; end
      6'd32: begin u1 = 1; e.wb = 1; end
      6'd33: begin u1 = 1; e.wb = 1; e.cmd = 4'd2; end
      6'd36: begin u1 = 1; e.wb = 1; e.mr = 1; end
      6'd37: begin u1 = 1; u2 = 1; e.mw = 1; a2 = ins[25:21]; end
      6'd40: begin u1 = 1; e.br = 2'b01; end
      6'd41: begin u1 = 1; u2 = 1; e.br = 2'b10; end
      6'd42: e.br = 2'b11;
      6'd0:  ;
      default: legal = 0;
    endcase
    if (rtype) begin u1 = 1; u2 = 1; e.wb = 1; end
    e.v1   = rf[ins[20:16]];
    e.v2   = rtype ? rf[a2] : imm;
    e.sv   = rf[a2];
    e.dest = ins[25:21];
  endfunction

  function automatic bit hz_src(input logic [4:0] s);
    return (s != 5'd0) && ((exe_wb_en && s == exe_dest) || (mem_wb_en && s == mem_dest) ||
                           (m_valid && m_wb && s == m_dest));
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    exp_t e;
    bit u1, u2, lg, hz, rdy, acc;
    logic [4:0] a2;
    #1;
    model(instr, e, u1, u2, a2, lg);
    hz  = (u1 && hz_src(instr[20:16])) || (u2 && hz_src(a2));
    rdy = !hz && !flush && (!m_valid || out_ready);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    if (in_valid) chk("rf_addr2", 32'(rf_addr2), 32'(a2));
    if (m_valid && q.size() > 0) begin
      chk("exe_cmd", 32'(exe_cmd), 32'(q[0].cmd));
      chk("val1", val1, q[0].v1);
      chk("val2", val2, q[0].v2);
      chk("st_val", st_val, q[0].sv);
      chk("dest", 32'(dest), 32'(q[0].dest));
      chk("wb_en", 32'(wb_en), 32'(q[0].wb));
      chk("mem_r", 32'(mem_r), 32'(q[0].mr));
      chk("mem_w", 32'(mem_w), 32'(q[0].mw));
      chk("br_type", 32'(br_type), 32'(q[0].br));
    end
`ifdef ILLEGAL_OP_TRAP_EN
    chk("illegal_op", 32'(illegal_op), 32'(m_ill));
`endif
    acc = in_valid && rdy;
    if (rst) begin
      q.delete();
      m_valid = 0; m_wb = 0; m_dest = 0; m_stall = 0; m_ill = 0;
    end else begin
      if (in_valid && hz && m_stall != SMAX) m_stall++;
      m_ill = acc && !lg;
      if (m_valid && (flush || out_ready) && q.size() > 0) void'(q.pop_front());
      if (flush) begin
        m_valid = 0; m_wb = 0;
      end else if (acc) begin
        q.push_back(e);
        m_valid = 1; m_wb = e.wb; m_dest = e.dest;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input int op, input int d, input int s1, input int s2);
    return {op[5:0], d[4:0], s1[4:0], s2[4:0], 11'h000};
  endfunction

  function automatic logic [31:0] mki(input int op, input int d, input int s1, input logic [15:0] imm);
    return {op[5:0], d[4:0], s1[4:0], imm};
  endfunction

  int ops [18] = '{0, 1, 3, 5, 6, 7, 8, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42, 63};

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    rst = 1; flush = 0; in_valid = 0; instr = 0; out_ready = 1;
    exe_dest = 0; exe_wb_en = 0; mem_dest = 0; mem_wb_en = 0;
    m_valid = 0; m_wb = 0; m_dest = 0; m_stall = 0; m_ill = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1 chk("reset_exe_cmd", 32'(exe_cmd), 32'd0);
    step();

    // ADD d3 s1=1 s2=2 with 5/7
    rf[1] = 5; rf[2] = 7;
    instr = mk(1, 3, 1, 2); in_valid = 1; step();
    in_valid = 0; step();
    // ADDI d4 s1=1 imm FFFE
    rf[1] = 10;
    instr = mki(32, 4, 1, 16'hFFFE); in_valid = 1; step();
    in_valid = 0; step();

    // RAW stall against EX, then release
    exe_dest = 1; exe_wb_en = 1;
    instr = mk(3, 5, 1, 2); in_valid = 1;
    repeat (3) step();
    exe_wb_en = 0; step();
    in_valid = 0; step();

    // Backpressure with two instructions
    out_ready = 0;
    instr = mk(5, 6, 2, 7); in_valid = 1; step();
    instr = mk(8, 7, 3, 4);
    repeat (3) step();
    out_ready = 1; step();
    in_valid = 0; step();
    step();

    // Flush while holding, with a new instruction offered
    out_ready = 0;
    instr = mki(36, 8, 2, 16'h0010); in_valid = 1; step();
    instr = mk(1, 9, 3, 4); flush = 1; step();
    flush = 0; in_valid = 0; step();
    out_ready = 1; step();

    // Reset in the middle of a stall
    exe_dest = 2; exe_wb_en = 1;
    instr = mk(1, 10, 2, 3); in_valid = 1;
    repeat (2) step();
    rst = 1; step();
    rst = 0; step();
    exe_wb_en = 0; in_valid = 0; step();

    // Stall counter saturation
    exe_wb_en = 1; instr = mk(1, 10, 2, 3); in_valid = 1;
    repeat (20) step();
    exe_wb_en = 0; step();
    in_valid = 0; step();

    // Unmapped opcode issues as NOP
    instr = {6'd63, 5'd11, 5'd1, 16'h1234}; in_valid = 1; step();
    in_valid = 0; step();
    step();

    // Mixed random traffic
    for (int n = 0; n < 400; n++) begin
      instr     = mki(ops[$urandom_range(0, 17)], $urandom_range(0, 7), $urandom_range(0, 7),
                      16'($urandom));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      exe_dest  = 5'($urandom_range(0, 7));
      exe_wb_en = ($urandom_range(0, 3) == 0);
      mem_dest  = 5'($urandom_range(0, 7));
      mem_wb_en = ($urandom_range(0, 3) == 0);
      step();
    end
    flush = 0; in_valid = 0; out_ready = 1; exe_wb_en = 0; mem_wb_en = 0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
